// File: rtl/meter_pkg.sv
// Shared types for the parking-meter controller: operation codes and pending-bit indices.
// Latency: none (package only).
// Backpressure: none (package only).
package meter_pkg;

    // Operation reported on op_code; the numeric value is visible on the port.
    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_LOAD1 = 3'd1,
        OP_LOAD0 = 3'd2,
        OP_TICK  = 3'd3,
        OP_INC   = 3'd4,
        OP_DEC   = 3'd5,
        OP_DBL   = 3'd6,
        OP_HALF  = 3'd7
    } op_e;

    // Pending-bit indices; a lower index means higher arbitration priority.
    localparam int NUM_SRC = 7;
    localparam int PI_P1   = 0;
    localparam int PI_P0   = 1;
    localparam int PI_TK   = 2;
    localparam int PI_UP   = 3;
    localparam int PI_DN   = 4;
    localparam int PI_LF   = 5;
    localparam int PI_RT   = 6;

    // Pending index i services operation code i+1.
    function automatic op_e src_op(input int idx);
        return op_e'(3'(idx + 1));
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Synchronises one raw board input, debounces it with a stable-count filter, emits a rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYC stable cycles, then a registered one-cycle rise pulse.
// Backpressure: none; the pulse is emitted unconditionally.
module input_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] stable_cnt;
    logic          accept;

    // The new level is accepted on the DEBOUNCE_CYC-th consecutive cycle it differs from the held level.
    assign accept = (sync_b != level) && (stable_cnt == CW'(DEBOUNCE_CYC - 1));

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Stable counter, debounced level and rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
        end else begin
            if (sync_b == level || accept) begin
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
            if (accept) begin
                level <= sync_b;
            end
            rise <= accept & sync_b;
        end
    end

endmodule

// File: rtl/meter_ctrl.sv
// Parking-meter sequencer: queues debounced presses and the 1 s tick, applies one op per cycle to t_meter.
// Latency: pending bit to t_meter update is 1 cycle, plus 1 cycle per higher-priority bit pending.
// Backpressure: none; repeat edges on an already-pending source merge into the one pending bit.
module meter_ctrl
    import meter_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int TICK_CYC     = CLK_HZ,
    parameter int MAX_TIME     = 9999,
    parameter int PRESET0      = 10,
    parameter int PRESET1      = 205
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        sw0,
    input  logic        sw1,
    output logic [15:0] t_meter,
    output logic        op_valid,
    output logic [2:0]  op_code,
    output logic        expired,
    output logic        busy
);

    localparam int          TW    = $clog2(TICK_CYC + 1);
    localparam logic [15:0] MAX_T = 16'(MAX_TIME);

    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] pend_next;
    logic [NUM_SRC-1:0] grant;
    op_e                sel_op;
    logic [TW-1:0]      tick_cnt;
    logic               tick_fire;
    logic [15:0]        t_next;
    logic [16:0]        t_dbl;

    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sw1 (.clk(clk), .rst_n(rst_n), .raw(sw1),       .rise(set_vec[PI_P1]));
    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sw0 (.clk(clk), .rst_n(rst_n), .raw(sw0),       .rise(set_vec[PI_P0]));
    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up  (.clk(clk), .rst_n(rst_n), .raw(btn_up),    .rise(set_vec[PI_UP]));
    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn  (.clk(clk), .rst_n(rst_n), .raw(btn_down),  .rise(set_vec[PI_DN]));
    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lf  (.clk(clk), .rst_n(rst_n), .raw(btn_left),  .rise(set_vec[PI_LF]));
    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_rt  (.clk(clk), .rst_n(rst_n), .raw(btn_right), .rise(set_vec[PI_RT]));

    // Tick source joins the pending set alongside the debounced edges.
    assign tick_fire       = (tick_cnt == TW'(TICK_CYC - 1));
    assign set_vec[PI_TK]  = tick_fire;

    // Free-running countdown tick: first TK pending lands TICK_CYC cycles after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_fire) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Fixed-priority arbiter: the lowest set index wins (scan runs high to low so the last hit sticks).
    always_comb begin
        grant  = '0;
        sel_op = OP_IDLE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant  = NUM_SRC'(1) << i;
                sel_op = src_op(i);
            end
        end
    end

    // A new edge wins over the service clear, so nothing arriving during service is dropped.
    assign pend_next = (pend & ~grant) | set_vec;

    // Meter datapath; doubling is formed in 17 bits so the ceiling compare cannot wrap.
    assign t_dbl = {t_meter, 1'b0};

    always_comb begin
        t_next = t_meter;
        case (sel_op)
            OP_LOAD1: t_next = 16'(PRESET1);
            OP_LOAD0: t_next = 16'(PRESET0);
            OP_TICK,
            OP_DEC:   t_next = (t_meter != 16'd0) ? t_meter - 16'd1 : t_meter;
            OP_INC:   t_next = (t_meter >= MAX_T) ? MAX_T : t_meter + 16'd1;
            OP_DBL:   t_next = (t_dbl > {1'b0, MAX_T}) ? MAX_T : t_dbl[15:0];
            OP_HALF:  t_next = t_meter >> 1;
            default:  t_next = t_meter;
        endcase
    end

    // Pending set, meter value and status flags all update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            t_meter  <= 16'd0;
            op_valid <= 1'b0;
            op_code  <= OP_IDLE;
            expired  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            pend     <= pend_next;
            t_meter  <= t_next;
            op_valid <= |pend;
            op_code  <= sel_op;
            expired  <= (t_next == 16'd0);
            busy     <= |pend_next;
        end
    end

endmodule

// File: tb/tb_meter_ctrl.sv
module tb_meter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        btn_up, btn_down, btn_left, btn_right, sw0, sw1;
    logic [15:0] t_meter;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        expired;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    meter_ctrl #(
        .CLK_HZ(100_000_000),
        .DEBOUNCE_CYC(4),
        .TICK_CYC(64),
        .MAX_TIME(9999),
        .PRESET0(10),
        .PRESET1(205)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .sw0(sw0),
        .sw1(sw1),
        .t_meter(t_meter),
        .op_valid(op_valid),
        .op_code(op_code),
        .expired(expired),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; TK becomes pending when cyc is a multiple of 64.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // mask bits: 0 sw1, 1 sw0, 2 up, 3 down, 4 left, 5 right
    task automatic set_raw(input logic [5:0] mask);
        sw1       = mask[0];
        sw0       = mask[1];
        btn_up    = mask[2];
        btn_down  = mask[3];
        btn_left  = mask[4];
        btn_right = mask[5];
    endtask

    // Advance to the next negedge where cyc % 64 == ph.
    task automatic wait_phase(input int ph);
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            if (cyc % 64 == ph) break;
            @(negedge clk);
        end
    endtask

    // Hold the inputs in mask until the first op_valid (bounded), then release them.
    task automatic press_wait(input logic [5:0] mask, output bit got);
        got = 1'b0;
        set_raw(mask);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_valid) begin
                got = 1'b1;
                break;
            end
        end
        set_raw(6'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_raw(6'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (t_meter !== 16'd0) begin n_fail++; $display("FAIL reset_t: got %0d expected 0", t_meter); end
        n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid: got %b expected 0", op_valid); end
        n_checks++; if (op_code !== 3'd0) begin n_fail++; $display("FAIL reset_op_code: got %0d expected 0", op_code); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (expired !== 1'b1) begin n_fail++; $display("FAIL reset_expired: got %b expected 1", expired); end
        rst_n = 1'b1;
    endtask

    task automatic test_floor();
        bit got;
        wait_phase(2);
        press_wait(6'b001000, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL floor_dec_timeout: got no op_valid expected one"); end
        n_checks++; if (op_code !== 3'd5) begin n_fail++; $display("FAIL floor_dec_code: got %0d expected 5", op_code); end
        n_checks++; if (t_meter !== 16'd0) begin n_fail++; $display("FAIL floor_dec_t: got %0d expected 0", t_meter); end
        n_checks++; if (expired !== 1'b1) begin n_fail++; $display("FAIL floor_expired: got %b expected 1", expired); end
        // first tick after reset, at zero: reported but no change
        wait_phase(1);
        n_checks++; if (cyc !== 65) begin n_fail++; $display("FAIL first_tick_cycle: got %0d expected 65", cyc); end
        n_checks++; if (op_valid !== 1'b1 || op_code !== 3'd3) begin n_fail++; $display("FAIL floor_tick_op: got valid %b code %0d expected 1/3", op_valid, op_code); end
        n_checks++; if (t_meter !== 16'd0) begin n_fail++; $display("FAIL floor_tick_t: got %0d expected 0", t_meter); end
    endtask

    task automatic test_load_tick();
        bit got;
        wait_phase(2);
        press_wait(6'b000001, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL load1_timeout: got no op_valid expected one"); end
        n_checks++; if (op_code !== 3'd1) begin n_fail++; $display("FAIL load1_code: got %0d expected 1", op_code); end
        n_checks++; if (t_meter !== 16'd205) begin n_fail++; $display("FAIL load1_t: got %0d expected 205", t_meter); end
        n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL load1_expired: got %b expected 0", expired); end
        @(negedge clk);
        n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL load1_pulse_width: got %b expected 0", op_valid); end
        wait_phase(1);
        n_checks++; if (op_valid !== 1'b1 || op_code !== 3'd3) begin n_fail++; $display("FAIL tick1_op: got valid %b code %0d expected 1/3", op_valid, op_code); end
        n_checks++; if (t_meter !== 16'd204) begin n_fail++; $display("FAIL tick1_t: got %0d expected 204", t_meter); end
        wait_phase(1);
        n_checks++; if (t_meter !== 16'd203) begin n_fail++; $display("FAIL tick2_t: got %0d expected 203", t_meter); end
    endtask

    task automatic test_saturate();
        bit got;
        logic [15:0] dbl_exp [6] = '{16'd408, 16'd814, 16'd1626, 16'd3250, 16'd6498, 16'd9999};
        wait_phase(2);
        press_wait(6'b000001, got);
        n_checks++; if (!got || t_meter !== 16'd205) begin n_fail++; $display("FAIL sat_load_t: got %0d expected 205", t_meter); end
        // each window: tick subtracts 1, then left doubles
        for (int k = 0; k < 6; k++) begin
            wait_phase(2);
            press_wait(6'b010000, got);
            n_checks++;
            if (!got || op_code !== 3'd6 || t_meter !== dbl_exp[k]) begin
                n_fail++;
                $display("FAIL dbl_step%0d: got code %0d t %0d expected code 6 t %0d", k, op_code, t_meter, dbl_exp[k]);
            end
        end
        press_wait(6'b000100, got);
        n_checks++; if (!got || op_code !== 3'd4 || t_meter !== 16'd9999) begin n_fail++; $display("FAIL inc_at_max: got code %0d t %0d expected code 4 t 9999", op_code, t_meter); end
        wait_phase(2);
        press_wait(6'b100000, got);
        n_checks++; if (!got || op_code !== 3'd7 || t_meter !== 16'd4999) begin n_fail++; $display("FAIL half_9998: got code %0d t %0d expected code 7 t 4999", op_code, t_meter); end
    endtask

    task automatic test_simultaneous();
        bit got;
        wait_phase(2);
        press_wait(6'b000010, got);
        n_checks++; if (!got || op_code !== 3'd2 || t_meter !== 16'd10) begin n_fail++; $display("FAIL sim_load0: got code %0d t %0d expected code 2 t 10", op_code, t_meter); end
        press_wait(6'b111100, got);
        n_checks++; if (!got || op_code !== 3'd4 || t_meter !== 16'd11 || busy !== 1'b1) begin n_fail++; $display("FAIL sim_inc: got code %0d t %0d busy %b expected 4/11/1", op_code, t_meter, busy); end
        @(negedge clk);
        n_checks++; if (op_valid !== 1'b1 || op_code !== 3'd5 || t_meter !== 16'd10 || busy !== 1'b1) begin n_fail++; $display("FAIL sim_dec: got valid %b code %0d t %0d busy %b expected 1/5/10/1", op_valid, op_code, t_meter, busy); end
        @(negedge clk);
        n_checks++; if (op_valid !== 1'b1 || op_code !== 3'd6 || t_meter !== 16'd20 || busy !== 1'b1) begin n_fail++; $display("FAIL sim_dbl: got valid %b code %0d t %0d busy %b expected 1/6/20/1", op_valid, op_code, t_meter, busy); end
        @(negedge clk);
        n_checks++; if (op_valid !== 1'b1 || op_code !== 3'd7 || t_meter !== 16'd10 || busy !== 1'b0) begin n_fail++; $display("FAIL sim_half: got valid %b code %0d t %0d busy %b expected 1/7/10/0", op_valid, op_code, t_meter, busy); end
        @(negedge clk);
        n_checks++; if (op_valid !== 1'b0 || op_code !== 3'd0) begin n_fail++; $display("FAIL sim_idle: got valid %b code %0d expected 0/0", op_valid, op_code); end
    endtask

    task automatic test_bounce();
        int n_ops;
        int n_inc;
        logic [15:0] last_t;
        wait_phase(2);
        // 3-cycle glitch: too short to be accepted
        n_ops = 0;
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        btn_up = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (op_valid || busy) n_ops++;
        end
        n_checks++; if (n_ops !== 0) begin n_fail++; $display("FAIL bounce_ignored: got %0d active cycles expected 0", n_ops); end
        // long press: exactly one increment
        n_ops = 0; n_inc = 0; last_t = 16'hFFFF;
        btn_up = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (i == 20) btn_up = 1'b0;
            if (op_valid) begin
                n_ops++;
                if (op_code == 3'd4) n_inc++;
                last_t = t_meter;
            end
        end
        n_checks++; if (n_ops !== 1 || n_inc !== 1) begin n_fail++; $display("FAIL held_press_ops: got %0d ops %0d inc expected 1/1", n_ops, n_inc); end
        n_checks++; if (last_t !== 16'd10) begin n_fail++; $display("FAIL held_press_t: got %0d expected 10", last_t); end
    endtask

    task automatic test_tick_collide();
        bit got;
        wait_phase(2);
        press_wait(6'b000010, got);
        press_wait(6'b100000, got);
        n_checks++; if (!got || op_code !== 3'd7 || t_meter !== 16'd5) begin n_fail++; $display("FAIL collide_setup: got code %0d t %0d expected code 7 t 5", op_code, t_meter); end
        // up becomes pending on the same edge as the tick
        wait_phase(57);
        btn_up = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_valid) begin got = 1'b1; break; end
        end
        n_checks++; if (!got || op_code !== 3'd3 || t_meter !== 16'd4) begin n_fail++; $display("FAIL collide_tick_first: got code %0d t %0d expected code 3 t 4", op_code, t_meter); end
        @(negedge clk);
        n_checks++; if (op_valid !== 1'b1 || op_code !== 3'd4 || t_meter !== 16'd5) begin n_fail++; $display("FAIL collide_inc_second: got valid %b code %0d t %0d expected 1/4/5", op_valid, op_code, t_meter); end
        btn_up = 1'b0;
    endtask

    task automatic test_reset_midqueue();
        bit seen;
        int n_act;
        wait_phase(2);
        seen = 1'b0;
        set_raw(6'b001110);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen || op_valid !== 1'b0) begin n_fail++; $display("FAIL midq_setup: got busy %b valid %b expected 1/0", seen, op_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (t_meter !== 16'd0 || busy !== 1'b0 || op_valid !== 1'b0 || expired !== 1'b1) begin n_fail++; $display("FAIL midq_async_reset: got t %0d busy %b valid %b expired %b expected 0/0/0/1", t_meter, busy, op_valid, expired); end
        set_raw(6'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_valid || busy) n_act++;
        end
        n_checks++; if (n_act !== 0 || t_meter !== 16'd0) begin n_fail++; $display("FAIL midq_no_stale: got %0d active cycles t %0d expected 0/0", n_act, t_meter); end
    endtask

    initial begin
        test_reset();
        test_floor();
        test_load_tick();
        test_saturate();
        test_simultaneous();
        test_bounce();
        test_tick_collide();
        test_reset_midqueue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/meter_ctrl.md
# meter_ctrl

Sequencing controller for the parking-meter time register. It debounces the four direction buttons and two preset switches and queues each press as a pending request. Requests are arbitrated with the one-second countdown tick, and one operation per cycle is applied to a single shared 16-bit meter value. The block sits between the board inputs and the display driver. It is the sole writer of `t_meter`.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency.
- `DEBOUNCE_CYC`, 1_000_000: cycles an input must stay stable before it is accepted.
- `TICK_CYC`, `CLK_HZ`: cycles per countdown tick (1 s).
- `MAX_TIME`, 9999: saturation ceiling for `t_meter`.
- `PRESET0`, 10: value loaded by `sw0`.
- `PRESET1`, 205: value loaded by `sw1`.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: raw asynchronous pushbuttons.
- `sw0`, `sw1` in 1 each: raw asynchronous preset switches.
- `t_meter` out 16: remaining time in seconds, range 0..`MAX_TIME`.
- `op_valid` out 1: one-cycle pulse, high in the cycle `t_meter` takes a new value.
- `op_code` out 3: operation applied, valid with `op_valid`.
- `expired` out 1: high while `t_meter == 0`.
- `busy` out 1: high while any pending bit is set.

## Operation
- Each raw input passes through a 2-flop synchronizer and a stable-count debouncer. A rising edge of the debounced level sets that input's pending bit.
- Pending set:
  - P1 (`sw1`)
  - P0 (`sw0`)
  - TK (tick)
  - UP, DN, LF, RT (buttons)
- TK is set every `TICK_CYC` cycles by a free-running counter.
- Each cycle the arbiter selects the highest-priority set bit, in fixed order P1 > P0 > TK > UP > DN > LF > RT. It applies that one operation and clears the bit.
- Operations on `t_meter` (t):
  - LOAD1: t = `PRESET1`.
  - LOAD0: t = `PRESET0`.
  - TICK: t = t-1 if t > 0, else no change. Still reported in `op_code` with `op_valid`.
  - INC: t = min(t+1, `MAX_TIME`).
  - DEC: t = max(t-1, 0).
  - DBL: t = min(2t, `MAX_TIME`). Compute in 17 bits before the compare.
  - HALF: t = t >> 1 (floor).
- `op_code` encoding: LOAD1 = 1, LOAD0 = 2, TICK = 3, INC = 4, DEC = 5, DBL = 6, HALF = 7. Value 0 means idle.
- Boundary rules:
  - A new edge on an input whose pending bit is already set merges with it. The extra press is lost.
  - A bit set in the same cycle it would be serviced is not lost; set takes precedence over clear for a different source.
  - Simultaneous edges on several inputs are all serviced, in priority order, in consecutive cycles.
  - Saturation at `MAX_TIME` and the floor at 0 never wrap.
- Reset, asynchronous at any point including mid-queue:
  - all pending bits cleared;
  - debounce and tick counters zeroed;
  - `t_meter` = 0, `op_valid` = 0, `op_code` = 0, `busy` = 0, `expired` = 1.

## Timing
- Debounce latency: 2 sync cycles + `DEBOUNCE_CYC` cycles of stable level, then edge detect. The pending bit is visible one cycle later.
- Service latency: the pending bit is set at cycle n; `t_meter`, `op_valid` and `op_code` update at the clock edge ending cycle n+1 when nothing of higher priority is pending. Each level below adds one cycle.
- `expired` and `busy` are registered and follow `t_meter` and the pending set in the same cycle.
- First TK pending after reset deassertion occurs `TICK_CYC` cycles later.
- Throughput: one operation per cycle; no back-pressure.

## Structure
- Shared package `meter_pkg`: `op_code` enum (`OP_IDLE` .. `OP_HALF`) and pending-bit index constants.
- Sub-module `input_debounce`, instantiated six times. It contains the synchronizer, stable counter and rising-edge pulse output, and is parameterised by `DEBOUNCE_CYC`.
- Top level holds the tick counter, pending register, priority arbiter and meter datapath.

## Test plan
Run with `DEBOUNCE_CYC` = 4 and `TICK_CYC` = 64.
- Reset, then `sw1` pulse -> `t_meter` = 205, `op_code` = 1, `expired` falls. Ticks then decrement by 1 every 64 cycles.
- `t_meter` = 9000, press left -> 9999 (saturate). Press right -> 4999. Press down at 0 -> stays 0.
- Press up, down, left and right in the same cycle at t = 10 -> four consecutive `op_valid` pulses: INC 11, DEC 10, DBL 20, HALF 10. `busy` is high for 4 cycles.
- Input bounce shorter than 4 cycles -> no pending bit and no `op_valid`. A press held 20 cycles -> exactly one INC.
- Tick coincides with a pending UP at t = 5 -> TICK applied first (4), then INC (5).
- Assert `rst_n` low mid-queue with 3 bits pending -> immediate `t_meter` = 0, `busy` = 0. After release, no stale operations are applied.
